dm_access_ctrl: RTL



---
 rtl/dm_pkg.sv | 62 ++++++
 rtl/be_gen.sv | 73 +++++++
 rtl/dm_access_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the MEM-stage data-memory sequencer:
//   - mem_op_e  : memory operation encodings driven by the MEM stage
//   - EXT_*     : load-extender opcodes (shared with the downstream Ext_2)
//   - state_e   : access sequencer states
//   - helpers   : lane-enable generation and extender opcode selection
// -----------------------------------------------------------------------------
package dm_pkg;

    // Memory operation encodings; values 9..15 are treated as "none".
    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LB   = 4'd2,
        OP_LBU  = 4'd3,
        OP_LH   = 4'd4,
        OP_LHU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    // Extender opcodes understood by Ext_2.
    localparam logic [2:0] EXT_W  = 3'b000;  // lw, stores and none
    localparam logic [2:0] EXT_B  = 3'b001;
    localparam logic [2:0] EXT_BU = 3'b010;
    localparam logic [2:0] EXT_H  = 3'b011;
    localparam logic [2:0] EXT_HU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // One-hot byte lane for a byte access.
    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Upper or lower half-word lanes, selected by addr[1].
    function automatic logic [3:0] half_be(input logic upper);
        return upper ? 4'b1100 : 4'b0011;
    endfunction

    // Extender opcode for a memory op; everything that is not a sub-word
    // load passes the word through untouched.
    function automatic logic [2:0] extop_of(input logic [3:0] op);
        logic [2:0] ext;
        case (op)
            OP_NONE, OP_LW: ext = EXT_W;
            OP_LB:          ext = EXT_B;
            OP_LBU:         ext = EXT_BU;
            OP_LH:          ext = EXT_H;
            OP_LHU:         ext = EXT_HU;
            default:        ext = EXT_W;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/be_gen.sv
// -----------------------------------------------------------------------------
// be_gen
// Purely combinational decode of one memory operation: lane enables, store
// data replicated into the lanes, alignment check and load/store class.
//
// Ports:
//   mem_op     in  4   operation encoding (see dm_pkg::mem_op_e)
//   addr_lo    in  2   byte offset within the word (addr[1:0])
//   wdata      in  32  store data, unshifted (low bytes significant)
//   be         out 4   lane enable for the access
//   wdata_lane out 32  store data replicated across the enabled lanes
//   misalign   out 1   access is not naturally aligned
//   is_load    out 1   operation is lw/lb/lbu/lh/lhu
//   is_store   out 1   operation is sw/sh/sb
// -----------------------------------------------------------------------------
module be_gen
    import dm_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic        is_load,
    output logic        is_store
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        be         = 4'b0000;
        wdata_lane = wdata;
        misalign   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;

        case (mem_op)
            OP_LW: begin
                is_load  = 1'b1;
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                be      = byte_be(addr_lo);
            end
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                be       = half_be(addr_lo[1]);
                misalign = addr_lo[0];
            end
            OP_SW: begin
                is_store = 1'b1;
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            OP_SH: begin
                is_store   = 1'b1;
                be         = half_be(addr_lo[1]);
                wdata_lane = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            OP_SB: begin
                is_store   = 1'b1;
                be         = byte_be(addr_lo);
                wdata_lane = {4{wdata[7:0]}};
            end
            default: ;  // none / reserved encodings: no access
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// MEM-stage data-memory sequencer. Accepts one aligned load/store per
// instruction, runs a ready-handshake transaction against a variable-latency
// data memory while stalling the pipeline, and hands the raw read word, lane
// enable and extender opcode to Ext_2. Misaligned accesses raise adel/ades
// instead of starting a transaction; a memory that never answers raises
// bus_err after TIMEOUT busy cycles.
//
// Parameters:
//   TIMEOUT  maximum BUSY cycles before a bus error (1..65535)
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req, mem_op       MEM stage holds a valid memory instruction / its op
//   addr, wdata       byte address / unshifted store data
//   flush             kill the instruction in the accept cycle
//   stall             freeze pipeline (combinational)
//   dm_req, dm_we     memory request / write request
//   dm_addr           word-aligned address
//   dm_wdata, dm_be   lane-replicated store data / lane enable
//   dm_ready          memory accepted / returned data
//   dm_rdata          read word from memory
//   DM, BE, extop_2   registered read word, lane enable, extender opcode
//   done              one-cycle completion pulse
//   adel, ades        load / store misalignment pulse
//   bus_err           memory timeout pulse
// -----------------------------------------------------------------------------
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic [31:0] DM,
    output logic [3:0]  BE,
    output logic [2:0]  extop_2,
    output logic        done,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter value during the last allowed BUSY cycle (it counts from 0).
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state;
    logic [CW-1:0] cnt;

    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic        misalign;
    logic        is_load;
    logic        is_store;

    logic        in_idle;
    logic        in_busy;
    logic        live_req;
    logic        accept;
    logic        tmo_last;

    be_gen u_be_gen (
        .mem_op     (mem_op),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (be_dec),
        .wdata_lane (wdata_dec),
        .misalign   (misalign),
        .is_load    (is_load),
        .is_store   (is_store)
    );

    assign in_idle  = (state == S_IDLE);
    assign in_busy  = (state == S_BUSY);
    // A flushed instruction is dead: it neither starts an access nor traps.
    assign live_req = in_idle & req & ~flush;
    assign accept   = live_req & (is_load | is_store) & ~misalign;
    assign tmo_last = (cnt == CNT_LAST);

    // Exception pulses are combinational so they land in the same cycle as
    // the offending instruction (misalign) or the final BUSY cycle (timeout).
    assign adel    = live_req & is_load  & misalign;
    assign ades    = live_req & is_store & misalign;
    // A ready arriving in the last allowed cycle still wins over the timeout.
    assign bus_err = in_busy & tmo_last & ~dm_ready;

    assign stall   = accept | in_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, data path included, is reset so that a
            // reset mid-transaction leaves no stale address/data on the bus.
            state    <= S_IDLE;
            cnt      <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_be    <= '0;
            DM       <= '0;
            BE       <= '0;
            extop_2  <= EXT_W;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge value of the others regardless of order.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_BUSY;
                        cnt      <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_addr  <= {addr[31:2], 2'b00};
                        dm_wdata <= wdata_dec;
                        dm_be    <= be_dec;
                        BE       <= be_dec;
                        extop_2  <= extop_of(mem_op);
                    end
                end

                S_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (dm_ready) begin
                        // Stores keep the last loaded word on DM.
                        if (!dm_we) begin
                            DM <= dm_rdata;
                        end
                    end else if (tmo_last) begin
                        DM <= '0;
                    end
                    if (dm_ready || tmo_last) begin
                        state  <= S_DONE;
                        dm_req <= 1'b0;
                        done   <= 1'b1;
                    end
                end

                S_DONE: begin
                    // req is still the completing instruction here; ignore it.
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    dm_req <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule
